// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 encodings (ALU control, M-extension funct3, mul/div FSM states).
package riscv_pkg;
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} md_state_t;
   function automatic logic a_signed(input logic [2:0] op);
      return op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM;
   endfunction
   function automatic logic b_signed(input logic [2:0] op);
      return op == OP_MULH || op == OP_DIV || op == OP_REM;
   endfunction
endpackage

// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative RV32M multiply/divide, one magnitude step per cycle, sign fix-up at the end.
module riscv_muldiv
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
   md_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] op_q, op_d;
   logic [XLEN-1:0] opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
   logic neg_a_q, neg_a_d, neg_b_q, neg_b_d, bz_q, bz_d;
   logic [XLEN-1:0] a_mag, b_mag, diff, mul_hi, quo, rem;
   logic [XLEN:0] add_sum, rem_sh;
   logic ge;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         bz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         bz_q     <= bz_d;
      end
   end
   always_comb begin
      state_d = state_q == S_IDLE ? (start ? S_CALC : S_IDLE)
              : state_q == S_CALC ? (cnt_q == LAST ? S_FIX : S_CALC)
              : state_q == S_FIX  ? S_DONE : S_IDLE;
   end
   always_comb begin
      busy   = state_q != S_IDLE;
      done   = state_q == S_DONE;
      result = result_q;
   end
   always_comb begin
      a_mag   = (a_signed(op) && srcA[XLEN-1]) ? -srcA : srcA;
      b_mag   = (b_signed(op) && srcB[XLEN-1]) ? -srcB : srcB;
      add_sum = {1'b0, hi_q} + {1'b0, opnd_q & {XLEN{lo_q[0]}}};
      rem_sh  = {hi_q, lo_q[XLEN-1]};
      ge      = rem_sh >= {1'b0, opnd_q};
      diff    = rem_sh[XLEN-1:0] - opnd_q;
      // high half of the negated 2*XLEN product: borrow propagates only when the low half is zero
      mul_hi  = (neg_a_q ^ neg_b_q) ? ~hi_q + XLEN'(lo_q == '0) : hi_q;
      quo     = bz_q ? '1 : (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
      rem     = neg_a_q ? -hi_q : hi_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      bz_d     = bz_q;
      if (state_q == S_IDLE && start) begin
         cnt_d   = '0;
         op_d    = op;
         neg_a_d = a_signed(op) && srcA[XLEN-1];
         neg_b_d = b_signed(op) && srcB[XLEN-1];
         bz_d    = srcB == '0;
         opnd_d  = op[2] ? b_mag : a_mag;
         hi_d    = '0;
         lo_d    = op[2] ? a_mag : b_mag;
      end else if (state_q == S_CALC) begin
         cnt_d = cnt_q + 1'b1;
         if (op_q[2]) begin
            hi_d = ge ? diff : rem_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ge};
         end else
            {hi_d, lo_d} = {add_sum, lo_q[XLEN-1:1]};
      end else if (state_q == S_FIX)
         result_d = !op_q[2] ? (op_q == OP_MUL ? lo_q : mul_hi) : (op_q[1] ? rem : quo);
   end
endmodule

// File: tb/tb_riscv_muldiv.sv
// tb_riscv_muldiv: directed vectors with hand-computed results, latency and control checks.
module tb_riscv_muldiv;
   import riscv_pkg::*;
   logic clk = 1'b0, reset = 1'b0, start = 1'b0, busy, done;
   logic [2:0] op = '0;
   logic [31:0] srcA = '0, srcB = '0, result;
   int checks = 0, errors = 0;
   riscv_muldiv #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
      .busy(busy), .done(done), .result(result)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask
   task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op = o; srcA = a; srcB = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask
   task automatic wait_done(output int n, output logic busy_ok);
      n = 1;
      busy_ok = 1'b1;
      while (!done && n < 60) begin
         busy_ok &= busy;
         @(posedge clk); #1;
         n++;
      end
      busy_ok &= busy;
   endtask
   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
      int n;
      logic bok;
      launch(o, a, b);
      wait_done(n, bok);
      check({tag, "_lat"}, n, 34);
      check({tag, "_busy"}, {31'b0, bok}, 1);
      check({tag, "_res"}, result, exp);
      @(posedge clk); #1;
      check({tag, "_pulse"}, {30'b0, done, busy}, 0);
   endtask
   initial begin
      int n, dones;
      logic [31:0] seen;
      #12;
      check("rst_out", {busy, done, result}, 0);
      start = 1'b1;
      @(posedge clk); #1;
      check("rst_nostart", {31'b0, busy}, 0);
      start = 1'b0;
      @(negedge clk) reset = 1'b1;
      run("mul", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
      run("mulh", OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000);
      run("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      run("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
      run("mulh_mix", OP_MULH, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
      run("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
      run("rem", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
      run("divu", OP_DIVU, 32'd100, 32'd7, 32'd14);
      run("remu", OP_REMU, 32'd100, 32'd7, 32'd2);
      run("divu_z", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF);
      run("remu_z", OP_REMU, 32'd5, 32'd0, 32'd5);
      run("div_z", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF);
      run("rem_z", OP_REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
      run("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      run("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0);
      launch(OP_MUL, 32'd3, 32'd5);
      repeat (4) @(posedge clk);
      @(negedge clk);
      op = OP_DIVU; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 6;
      dones = 0;
      seen = '0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         n++;
         if (done) begin
            dones++;
            seen = (dones == 1) ? n : seen;
            check("ign_res", result, 32'd15);
         end
      end
      check("ign_lat", seen, 34);
      check("ign_dones", dones, 1);
      launch(OP_MUL, 32'h1234, 32'h10);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("mid_rst", {busy, done, result}, 0);
      @(negedge clk) reset = 1'b1;
      dones = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (done || busy) dones++;
      end
      check("post_rst_idle", dones, 0);
      run("fresh", OP_MUL, 32'h1234, 32'h10, 32'h12340);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/riscv_muldiv.md
RISCV_MULDIV -- requirements
Module: riscv_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width (even, >= 8).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request strobe, sampled only while busy=0.
REQ-005 SHALL have port op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have port srcA  input  XLEN  rs1 operand (multiplicand/dividend).
REQ-007 SHALL have port srcB  input  XLEN  rs2 operand (multiplier/divisor).
REQ-008 SHALL have port busy  output  1  high from the edge accepting start until done deasserts.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port result  output  XLEN  registered result, held until next accepted start.

Function
REQ-011 SHALL be a state machine IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-012 SHALL, in IDLE with start=1, capture op, srcA, srcB and sign info, clear the iteration counter, and enter CALC.
REQ-013 SHALL ignore start while busy=1: no capture, no effect on the operation in flight.
REQ-014 SHALL stay in CALC exactly XLEN cycles, one iteration per cycle: shift-add for multiply on magnitudes, restoring shift-subtract for divide on magnitudes.
REQ-015 SHALL, in FIX (one cycle), apply sign correction, select low/high product half or quotient/remainder, and register result.
REQ-016 SHALL assert done and busy in DONE for exactly one cycle, then return to IDLE; done rises XLEN+2 edges after the accepting edge, for every op.
REQ-017 SHALL treat operands as signed×signed (MULH, DIV, REM), signed×unsigned (MULHSU), or unsigned otherwise; product width 2*XLEN.
REQ-018 SHALL return, for divisor 0: DIV/DIVU quotient all ones; REM/REMU = srcA; same latency.
REQ-019 SHALL return, for DIV/REM with srcA = signed minimum and srcB = -1: quotient = srcA, remainder = 0.
REQ-020 SHALL give the remainder the sign of the dividend and truncate the quotient toward zero.
REQ-021 SHALL accept a new start in the cycle after done (IDLE), giving back-to-back throughput of one op per XLEN+3 cycles.

Reset
REQ-022 SHALL, on reset low, asynchronously force state IDLE, busy=0, done=0, result=0, counter and internal registers 0.
REQ-023 SHALL abandon any operation in flight at reset; no done pulse follows reset release.
REQ-024 SHALL not accept start in a cycle where reset is low.

Structure
REQ-025 SHALL take the op encodings (funct3 constants) and state encoding from shared package riscv_pkg, alongside the ALU control constants.
REQ-026 SHALL be a single module; no sub-module is required, the sign-fix logic staying local combinational code.
REQ-027 SHALL contain no combinational path from any input to done, busy or result.

Verification (XLEN=32)
REQ-028 SHALL verify MUL 7 × 0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 34 edges after start, busy high throughout.
REQ-029 SHALL verify MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
REQ-030 SHALL verify DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-031 SHALL verify DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0.
REQ-032 SHALL verify start pulsed with new operands at CALC cycle 5 -> ignored; first op's result unchanged, single done pulse.
REQ-033 SHALL verify reset low at CALC cycle 10 -> busy=0, done=0, result=0 immediately; no done afterwards; fresh op after release completes correctly.
